bus_arbiter_2h: RTL and testbench

- Two-host arbiter sharing one bus hub host port (addr/wdata/wmask/ren/wen/rdata/ready protocol) between requesters, e.g. the pipelined core and a future framebuffer DMA engine feeding the HUB75 driver.
- Grants whole transactions with round-robin fairness.
- Forwards one granted transaction at a time to the device side.
- Provides a watchdog timeout so a stuck device cannot hang either host.

---
 rtl/bus_arbiter_2h.sv | 126 ++++++++++++
 tb/tb_bus_arbiter_2h.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter_2h.sv
// Two-host round-robin arbiter in front of the bus hub host port.
// It grants whole transactions and has a watchdog that completes a stuck transfer with an error.
module bus_arbiter_2h #(
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter logic [31:0] ERR_RDATA      = 32'hDEADBEEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] h0_addr,
    input  logic [31:0] h0_wdata,
    input  logic [3:0]  h0_wmask,
    input  logic        h0_ren,
    input  logic        h0_wen,
    output logic [31:0] h0_rdata,
    output logic        h0_ready,
    input  logic [31:0] h1_addr,
    input  logic [31:0] h1_wdata,
    input  logic [3:0]  h1_wmask,
    input  logic        h1_ren,
    input  logic        h1_wen,
    output logic [31:0] h1_rdata,
    output logic        h1_ready,
    output logic [31:0] dev_addr,
    output logic [31:0] dev_wdata,
    output logic [3:0]  dev_wmask,
    output logic        dev_ren,
    output logic        dev_wen,
    input  logic [31:0] dev_rdata,
    input  logic        dev_ready,
    output logic [1:0]  grant,
    output logic        timeout_err
);

    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam bit WD_EN = (TIMEOUT_CYCLES != 0);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state;
    logic [1:0]    grant_q;
    logic          ptr;        // host that wins a tie: 0 = host0, 1 = host1
    logic [CW-1:0] cnt;
    logic          timeout_q;

    logic req0, req1, expire, done;

    assign req0   = h0_ren | h0_wen;
    assign req1   = h1_ren | h1_wen;
    assign expire = WD_EN && (state == BUSY) && !dev_ready && (cnt == LAST);
    assign done   = (state == BUSY) && (dev_ready || expire);

    assign grant       = grant_q;
    assign timeout_err = timeout_q;

    // Device side and host responses are combinational from the registered grant,
    // so an asynchronous reset drops dev_ren/dev_wen without waiting for a clock edge.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        dev_addr  = '0;
        dev_wdata = '0;
        dev_wmask = '0;
        dev_ren   = 1'b0;
        dev_wen   = 1'b0;
        h0_ready  = 1'b0;
        h0_rdata  = '0;
        h1_ready  = 1'b0;
        h1_rdata  = '0;
        if (grant_q[0]) begin
            dev_addr  = h0_addr;
            dev_wdata = h0_wdata;
            dev_wmask = h0_wmask;
            dev_ren   = h0_ren;
            dev_wen   = h0_wen;
            h0_ready  = done;
            if (done) h0_rdata = expire ? ERR_RDATA : dev_rdata;
        end else if (grant_q[1]) begin
            dev_addr  = h1_addr;
            dev_wdata = h1_wdata;
            dev_wmask = h1_wmask;
            dev_ren   = h1_ren;
            dev_wen   = h1_wen;
            h1_ready  = done;
            if (done) h1_rdata = expire ? ERR_RDATA : dev_rdata;
        end
    end

    // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            grant_q   <= 2'b00;
            ptr       <= 1'b0;
            cnt       <= '0;
            timeout_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // dev_ready is ignored here: it may be the trailing done pulse of memory.
                    cnt <= '0;
                    if (req0 || req1) begin
                        state <= BUSY;
                        if (req0 && (!req1 || !ptr)) grant_q <= 2'b01;
                        else                         grant_q <= 2'b10;
                    end
                end
                BUSY: begin
                    if (done) begin
                        state   <= IDLE;
                        grant_q <= 2'b00;
                        ptr     <= grant_q[0];
                        cnt     <= '0;
                        if (expire) timeout_q <= 1'b1;
                    end else if (WD_EN) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    grant_q <= 2'b00;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter_2h.sv
// Directed bench for bus_arbiter_2h: reset, single read, round-robin, trailing done,
// watchdog expiry (TIMEOUT_CYCLES=4) and asynchronous reset during a transfer.
module tb_bus_arbiter_2h;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] h0_addr, h0_wdata, h1_addr, h1_wdata;
    logic [3:0]  h0_wmask, h1_wmask;
    logic        h0_ren, h0_wen, h1_ren, h1_wen;
    logic [31:0] h0_rdata, h1_rdata;
    logic        h0_ready, h1_ready;
    logic [31:0] dev_addr, dev_wdata, dev_rdata;
    logic [3:0]  dev_wmask;
    logic        dev_ren, dev_wen, dev_ready;
    logic [1:0]  grant;
    logic        timeout_err;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    bus_arbiter_2h #(.TIMEOUT_CYCLES(4), .ERR_RDATA(32'hDEADBEEF)) dut (
        .clk(clk), .rst_n(rst_n),
        .h0_addr(h0_addr), .h0_wdata(h0_wdata), .h0_wmask(h0_wmask),
        .h0_ren(h0_ren), .h0_wen(h0_wen), .h0_rdata(h0_rdata), .h0_ready(h0_ready),
        .h1_addr(h1_addr), .h1_wdata(h1_wdata), .h1_wmask(h1_wmask),
        .h1_ren(h1_ren), .h1_wen(h1_wen), .h1_rdata(h1_rdata), .h1_ready(h1_ready),
        .dev_addr(dev_addr), .dev_wdata(dev_wdata), .dev_wmask(dev_wmask),
        .dev_ren(dev_ren), .dev_wen(dev_wen), .dev_rdata(dev_rdata), .dev_ready(dev_ready),
        .grant(grant), .timeout_err(timeout_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_hosts();
        h0_ren = 0; h0_wen = 0; h1_ren = 0; h1_wen = 0;
    endtask

    // Round-robin expectations, one per cycle starting with the IDLE cycle after reset
    logic [1:0]  rr_grant [8] = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10};

    initial begin
        rst_n = 0;
        h0_addr = 32'h100; h0_wdata = 32'hA0A0A0A0; h0_wmask = 4'hF;
        h1_addr = 32'h200; h1_wdata = 32'hB1B1B1B1; h1_wmask = 4'h3;
        idle_hosts();
        dev_rdata = 32'h0; dev_ready = 0;

        // Reset values with h0 already requesting
        h0_ren = 1;
        #12;
        check("rst_grant",   32'(grant), 32'h0);
        check("rst_dev_ren", 32'(dev_ren), 32'h0);
        check("rst_dev_addr", dev_addr, 32'h0);
        check("rst_h0_ready", 32'(h0_ready), 32'h0);
        check("rst_h0_rdata", h0_rdata, 32'h0);
        check("rst_timeout", 32'(timeout_err), 32'h0);
        rst_n = 1;

        // Single read: first BUSY cycle drives the device, answer one cycle later
        step();
        check("rd_grant",    32'(grant), 32'h1);
        check("rd_dev_ren",  32'(dev_ren), 32'h1);
        check("rd_dev_addr", dev_addr, 32'h100);
        check("rd_h0_early", 32'(h0_ready), 32'h0);
        step();
        dev_ready = 1; dev_rdata = 32'h12345678;
        #1;
        check("rd_h0_ready", 32'(h0_ready), 32'h1);
        check("rd_h0_rdata", h0_rdata, 32'h12345678);
        check("rd_h1_ready", 32'(h1_ready), 32'h0);
        // Trailing done: dev_ready stays high into the IDLE cycle
        step();
        h0_ren = 0;
        #1;
        check("td_grant",    32'(grant), 32'h0);
        check("td_h0_ready", 32'(h0_ready), 32'h0);
        check("td_dev_ren",  32'(dev_ren), 32'h0);
        dev_ready = 0;
        step();
        check("td_stay_idle", 32'(grant), 32'h0);

        // Round-robin from reset with both hosts held and an always-ready device
        #2 rst_n = 0;
        h0_ren = 1; h1_wen = 1; dev_ready = 1; dev_rdata = 32'h5555AAAA;
        #2 rst_n = 1;
        #1;
        check("rr_grant0", 32'(grant), 32'(rr_grant[0]));
        for (int i = 1; i < 8; i++) begin
            step();
            check($sformatf("rr_grant%0d", i), 32'(grant), 32'(rr_grant[i]));
            check($sformatf("rr_h0_ready%0d", i), 32'(h0_ready), 32'(rr_grant[i][0]));
            check($sformatf("rr_h1_ready%0d", i), 32'(h1_ready), 32'(rr_grant[i][1]));
            if (rr_grant[i] == 2'b10) begin
                check($sformatf("rr_dev_wen%0d", i), 32'(dev_wen), 32'h1);
                check($sformatf("rr_dev_addr%0d", i), dev_addr, 32'h200);
            end
        end

        // Watchdog: h1 writes, the device never answers
        #2 rst_n = 0;
        idle_hosts(); dev_ready = 0;
        h1_wen = 1; h1_addr = 32'h300;
        #2 rst_n = 1;
        for (int i = 1; i <= 3; i++) begin
            step();
            check($sformatf("wd_grant%0d", i), 32'(grant), 32'h2);
            check($sformatf("wd_h1_ready%0d", i), 32'(h1_ready), 32'h0);
        end
        step();
        check("wd_h1_ready4", 32'(h1_ready), 32'h1);
        check("wd_h1_rdata",  h1_rdata, 32'hDEADBEEF);
        check("wd_h0_ready",  32'(h0_ready), 32'h0);
        step();
        h1_wen = 0; h0_ren = 1; h0_addr = 32'h400;
        #1;
        check("wd_idle_grant", 32'(grant), 32'h0);
        check("wd_err_set",    32'(timeout_err), 32'h1);
        step();
        check("wd_h0_grant", 32'(grant), 32'h1);
        check("wd_h0_addr",  dev_addr, 32'h400);
        dev_ready = 1; dev_rdata = 32'hCAFEF00D;
        #1;
        check("wd_h0_ready", 32'(h0_ready), 32'h1);
        check("wd_h0_rdata", h0_rdata, 32'hCAFEF00D);
        step();
        h0_ren = 0; dev_ready = 0;
        #1;
        check("wd_err_sticky", 32'(timeout_err), 32'h1);

        // Async reset during a write; pointer currently favours host1
        h1_wen = 1; h1_addr = 32'h500;
        step();
        check("ar_grant", 32'(grant), 32'h2);
        check("ar_dev_wen_before", 32'(dev_wen), 32'h1);
        #2 rst_n = 0;
        #1;
        check("ar_dev_wen_after", 32'(dev_wen), 32'h0);
        check("ar_grant_after",   32'(grant), 32'h0);
        check("ar_h1_ready",      32'(h1_ready), 32'h0);
        check("ar_timeout_clr",   32'(timeout_err), 32'h0);
        h0_ren = 1; h0_addr = 32'h600;
        step();
        #2 rst_n = 1;
        step();
        check("ar_ptr_host0", 32'(grant), 32'h1);
        check("ar_dev_addr",  dev_addr, 32'h600);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
